spi_slave_burst: RTL and testbench

Parametrised SPI slave with internal register memory: the successor to the fixed 41-bit single-word SPI slave on the SPI side of the AHB-Lite-to-SPI bridge. It adds configurable data/address width, all four SPI modes (CPOL/CPHA), and burst transfers with address auto-increment while `cs` stays low. It also adds input synchronisation and framing-error reporting. It runs entirely in the SCLK domain and oversamples the master's `spi_clk`.

---
 rtl/spi_slave_burst.sv | 183 ++++++++++++++++++
 tb/tb_spi_slave_burst.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_burst.sv
// spi_slave_burst: oversampled SPI slave with a burst read/write register file.
// Ports: SCLK/SRESETn system clock and async active-low reset;
//        spi_clk/cs/mosi/miso SPI pins (cs active low, MSB first);
//        busy = frame active, frame_err = abort pulse, word_cnt = words done.
module spi_slave_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic        SCLK,
    input  logic        SRESETn,
    input  logic        spi_clk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] word_cnt
);
    localparam int SH_W  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(SH_W + 2);
    localparam logic [CNT_W-1:0] HDR_BITS  = CNT_W'(ADDR_W + 1);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WR_DATA,
        WR_COMMIT,
        RD_FETCH,
        RD_DATA,
        WAIT_CS
    } state_t;

    state_t state, state_n;

    logic [2:0]        clk_s;
    logic [1:0]        cs_s;
    logic [1:0]        mosi_s;
    logic              cs_hi;
    logic              mosi_d;
    logic              lead, trail, cap, launch;
    logic              abort;
    logic              cnt_last;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr;
    logic [SH_W-1:0]   sh_in;
    logic [SH_W-1:0]   shifted;
    logic [DATA_W-1:0] sh_out;
    logic              miso_q;
    logic [15:0]       wc_inc;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // cs sync resets to "low" so a frame already running at release
    // is ignored until cs has been seen high (WAIT_CS).
    always_ff @(posedge SCLK or negedge SRESETn) begin
        if (!SRESETn) begin
            clk_s  <= {3{CPOL}};
            cs_s   <= 2'b00;
            mosi_s <= 2'b00;
        end else begin
            clk_s  <= {clk_s[1:0], spi_clk};
            cs_s   <= {cs_s[0], cs};
            mosi_s <= {mosi_s[0], mosi};
        end
    end

    assign cs_hi    = cs_s[1];
    assign mosi_d   = mosi_s[1];
    assign lead     = (clk_s[1] != CPOL) && (clk_s[2] == CPOL);
    assign trail    = (clk_s[1] == CPOL) && (clk_s[2] != CPOL);
    assign cap      = CPHA ? trail : lead;
    assign launch   = CPHA ? lead : trail;
    assign cnt_last = (bit_cnt == CNT_W'(1));
    assign shifted  = {sh_in[SH_W-2:0], mosi_d};
    assign wc_inc   = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

    always_ff @(posedge SCLK or negedge SRESETn) begin
        if (!SRESETn) state <= WAIT_CS;
        else          state <= state_n;
    end

    // abort: cs rose after some but not all bits of a header/word
    always_comb begin
        state_n = state;
        abort   = 1'b0;
        unique case (state)
            IDLE:    if (!cs_hi) state_n = HEADER;
            WAIT_CS: if (cs_hi) state_n = IDLE;
            HEADER: begin
                if (cs_hi) begin
                    state_n = IDLE;
                    abort   = (bit_cnt != HDR_BITS);
                end else if (cap && cnt_last) begin
                    // sh_in[ADDR_W-1] holds the r/w bit here
                    state_n = sh_in[ADDR_W-1] ? WR_DATA : RD_FETCH;
                end
            end
            WR_DATA, RD_DATA: begin
                if (cs_hi) begin
                    state_n = IDLE;
                    abort   = (bit_cnt != WORD_BITS);
                end else if (cap && cnt_last) begin
                    state_n = (state == WR_DATA) ? WR_COMMIT : RD_FETCH;
                end
            end
            WR_COMMIT: state_n = cs_hi ? IDLE : WR_DATA;
            RD_FETCH:  state_n = cs_hi ? IDLE : RD_DATA;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge SCLK or negedge SRESETn) begin
        if (!SRESETn) begin
            bit_cnt   <= '0;
            addr      <= '0;
            sh_in     <= '0;
            sh_out    <= '0;
            miso_q    <= 1'b0;
            word_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
            unique case (state)
                IDLE: begin
                    if (!cs_hi) begin
                        bit_cnt  <= HDR_BITS;
                        word_cnt <= '0;
                    end
                end
                HEADER: begin
                    if (cap) begin
                        sh_in <= shifted;
                        if (cnt_last) begin
                            bit_cnt <= WORD_BITS;
                            addr    <= shifted[ADDR_W-1:0];
                        end else begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end
                end
                WR_DATA: begin
                    if (cap) begin
                        sh_in   <= shifted;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                WR_COMMIT: begin
                    addr     <= addr + ADDR_W'(1);
                    word_cnt <= wc_inc;
                    bit_cnt  <= WORD_BITS;
                end
                RD_FETCH: begin
                    sh_out  <= mem[addr];
                    addr    <= addr + ADDR_W'(1);
                    bit_cnt <= WORD_BITS;
                end
                RD_DATA: begin
                    if (launch) begin
                        miso_q <= sh_out[DATA_W-1];
                        sh_out <= sh_out << 1;
                    end
                    if (cap) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (cnt_last) word_cnt <= wc_inc;
                    end
                end
                default: ;
            endcase
            if (state_n == IDLE || state_n == WAIT_CS) miso_q <= 1'b0;
        end
    end

    // no reset on the array: contents survive SRESETn
    always_ff @(posedge SCLK) begin
        if (state == WR_COMMIT) mem[addr] <= sh_in[DATA_W-1:0];
    end

    assign miso = miso_q;
    assign busy = (state != IDLE) && (state != WAIT_CS);

endmodule

// File: tb/tb_spi_slave_burst.sv
// tb_spi_slave_burst: three spi_slave_burst configurations driven by a
// bit-level SPI master, checked against an array model of the register file.
module tb_spi_slave_burst;
    localparam int CLK  = 10;
    localparam int HALF = 50;
    localparam int AW [3] = '{8, 8, 4};
    localparam int DW [3] = '{32, 32, 16};
    localparam bit POL [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit PHA [3] = '{1'b0, 1'b1, 1'b1};

    logic        SCLK = 1'b0;
    logic        SRESETn = 1'b1;
    logic        sck [3];
    logic        csn [3];
    logic        mo [3];
    logic        so [3];
    logic        bsy [3];
    logic        ferr [3];
    logic [15:0] wc [3];

    int nchk = 0;
    int npass = 0;
    int ferr_cnt [3];
    int ferr_busy [3];

    logic [31:0] mem_m [3][256];
    bit          known [3][256];

    always #(CLK/2) SCLK = ~SCLK;

    spi_slave_burst #(.DATA_W(32), .ADDR_W(8), .CPOL(1'b0), .CPHA(1'b0)) u0 (
        .SCLK(SCLK), .SRESETn(SRESETn), .spi_clk(sck[0]), .cs(csn[0]),
        .mosi(mo[0]), .miso(so[0]), .busy(bsy[0]), .frame_err(ferr[0]),
        .word_cnt(wc[0]));
    spi_slave_burst #(.DATA_W(32), .ADDR_W(8), .CPOL(1'b1), .CPHA(1'b1)) u1 (
        .SCLK(SCLK), .SRESETn(SRESETn), .spi_clk(sck[1]), .cs(csn[1]),
        .mosi(mo[1]), .miso(so[1]), .busy(bsy[1]), .frame_err(ferr[1]),
        .word_cnt(wc[1]));
    spi_slave_burst #(.DATA_W(16), .ADDR_W(4), .CPOL(1'b0), .CPHA(1'b1)) u2 (
        .SCLK(SCLK), .SRESETn(SRESETn), .spi_clk(sck[2]), .cs(csn[2]),
        .mosi(mo[2]), .miso(so[2]), .busy(bsy[2]), .frame_err(ferr[2]),
        .word_cnt(wc[2]));

    always @(negedge SCLK) begin
        for (int i = 0; i < 3; i++) begin
            if (ferr[i] === 1'b1) ferr_cnt[i]++;
            if (ferr[i] === 1'b1 && bsy[i] !== 1'b0) ferr_busy[i]++;
        end
    end

    function automatic void push_word(inout bit q[$], input logic [31:0] v,
                                      input int n);
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    endfunction

    function automatic logic [31:0] get_word(input logic q[$], input int off,
                                             input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], q[off+i]};
        return r;
    endfunction

    function automatic logic [31:0] dmask(input int d);
        return (DW[d] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    task automatic spi_bits(input int d, input bit tx[$], output logic rx[$]);
        rx = {};
        foreach (tx[i]) begin
            if (!PHA[d]) begin
                mo[d] = tx[i];
                #HALF;
                rx.push_back(so[d]);
                sck[d] = ~POL[d];
                #HALF;
                sck[d] = POL[d];
            end else begin
                sck[d] = ~POL[d];
                mo[d] = tx[i];
                #HALF;
                rx.push_back(so[d]);
                sck[d] = POL[d];
                #HALF;
            end
        end
    endtask

    task automatic cs_lo(input int d);
        csn[d] = 1'b0;
        #HALF;
    endtask

    task automatic cs_hi(input int d);
        #HALF;
        csn[d] = 1'b1;
        #(12*CLK);
    endtask

    task automatic do_write(input int d, input int a, input logic [31:0] w[$]);
        bit tx[$];
        logic rx[$];
        int idx;
        push_word(tx, (32'd1 << AW[d]) | 32'(a), AW[d] + 1);
        foreach (w[i]) begin
            push_word(tx, w[i], DW[d]);
            idx = (a + i) % (1 << AW[d]);
            mem_m[d][idx] = w[i] & dmask(d);
            known[d][idx] = 1'b1;
        end
        cs_lo(d);
        spi_bits(d, tx, rx);
        cs_hi(d);
    endtask

    task automatic do_read(input int d, input int a, input int n,
                           output logic [31:0] r[$]);
        bit tx[$];
        logic rx[$];
        push_word(tx, 32'(a), AW[d] + 1);
        for (int i = 0; i < n; i++) push_word(tx, 32'd0, DW[d]);
        cs_lo(d);
        spi_bits(d, tx, rx);
        cs_hi(d);
        r = {};
        for (int i = 0; i < n; i++)
            r.push_back(get_word(rx, AW[d] + 1 + i * DW[d], DW[d]));
    endtask

    task automatic test_reset();
        SRESETn = 1'b0;
        #(3*CLK);
        for (int d = 0; d < 3; d++) begin
            nchk++;
            if ({so[d], bsy[d], ferr[d]} !== 3'b000 || wc[d] !== 16'd0)
                $display("FAIL reset_vals[%0d]: miso/busy/ferr=%b%b%b wc=%h required 000 0000",
                         d, so[d], bsy[d], ferr[d], wc[d]);
            else npass++;
        end
        SRESETn = 1'b1;
        #(5*CLK);
        for (int d = 0; d < 3; d++) begin
            nchk++;
            if (bsy[d] !== 1'b0 || so[d] !== 1'b0)
                $display("FAIL post_reset_idle[%0d]: busy=%b miso=%b required 0 0",
                         d, bsy[d], so[d]);
            else npass++;
        end
    endtask

    task automatic test_mode0_basic();
        bit tx[$];
        logic rx[$];
        logic [31:0] r[$];
        int fe;
        int nz;
        fe = ferr_cnt[0];
        push_word(tx, 32'h110, 9);
        push_word(tx, 32'hDEADBEEF, 32);
        cs_lo(0);
        nchk++;
        if (bsy[0] !== 1'b1) $display("FAIL busy_in_frame: got %b required 1", bsy[0]);
        else npass++;
        spi_bits(0, tx, rx);
        cs_hi(0);
        mem_m[0][8'h10] = 32'hDEADBEEF;
        known[0][8'h10] = 1'b1;
        nz = 0;
        foreach (rx[i]) if (rx[i] !== 1'b0) nz++;
        nchk++;
        if (nz != 0) $display("FAIL miso_quiet_write: got %0d nonzero bits required 0", nz);
        else npass++;
        nchk++;
        if (wc[0] !== 16'd1 || bsy[0] !== 1'b0)
            $display("FAIL write_wc: got wc=%h busy=%b required 0001 0", wc[0], bsy[0]);
        else npass++;
        do_read(0, 8'h10, 1, r);
        nchk++;
        if (r[0] !== 32'hDEADBEEF) $display("FAIL read_deadbeef: got %h required deadbeef", r[0]);
        else npass++;
        nchk++;
        if (wc[0] !== 16'd1 || so[0] !== 1'b0)
            $display("FAIL read_wc: got wc=%h miso=%b required 0001 0", wc[0], so[0]);
        else npass++;
        nchk++;
        if (ferr_cnt[0] != fe) $display("FAIL mode0_no_ferr: got %0d required %0d", ferr_cnt[0], fe);
        else npass++;
    endtask

    task automatic test_burst_wrap();
        logic [31:0] w[$];
        logic [31:0] r[$];
        int fe;
        fe = ferr_cnt[1];
        w = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_write(1, 8'hFE, w);
        nchk++;
        if (wc[1] !== 16'd3) $display("FAIL burst_wr_wc: got %h required 0003", wc[1]);
        else npass++;
        do_read(1, 8'hFE, 3, r);
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (r[i] !== mem_m[1][(8'hFE + i) % 256])
                $display("FAIL burst_rd[%0d]: got %h required %h", i, r[i], mem_m[1][(8'hFE + i) % 256]);
            else npass++;
        end
        nchk++;
        if (wc[1] !== 16'd3) $display("FAIL burst_rd_wc: got %h required 0003", wc[1]);
        else npass++;
        do_read(1, 0, 1, r);
        nchk++;
        if (r[0] !== 32'h33333333) $display("FAIL wrap_addr0: got %h required 33333333", r[0]);
        else npass++;
        nchk++;
        if (ferr_cnt[1] != fe) $display("FAIL burst_no_ferr: got %0d required %0d", ferr_cnt[1], fe);
        else npass++;
    endtask

    task automatic test_abort_word();
        logic [31:0] w[$];
        logic [31:0] r[$];
        bit tx[$];
        logic rx[$];
        int fe;
        w = '{$urandom};
        do_write(0, 8'h20, w);
        fe = ferr_cnt[0];
        push_word(tx, 32'h120, 9);
        push_word(tx, ~w[0], 32);
        tx = tx[0:9+17-1];
        cs_lo(0);
        spi_bits(0, tx, rx);
        cs_hi(0);
        nchk++;
        if (ferr_cnt[0] != fe + 1) $display("FAIL abort_word_ferr: got %0d pulses required 1", ferr_cnt[0] - fe);
        else npass++;
        nchk++;
        if (ferr_busy[0] != 0 || bsy[0] !== 1'b0 || wc[0] !== 16'd0)
            $display("FAIL abort_word_state: got ferr_busy=%0d busy=%b wc=%h required 0 0 0000",
                     ferr_busy[0], bsy[0], wc[0]);
        else npass++;
        do_read(0, 8'h20, 1, r);
        nchk++;
        if (r[0] !== mem_m[0][8'h20]) $display("FAIL abort_word_mem: got %h required %h", r[0], mem_m[0][8'h20]);
        else npass++;
    endtask

    task automatic test_abort_header();
        logic [31:0] w[$];
        logic [31:0] r[$];
        bit tx[$];
        logic rx[$];
        int fe;
        int a;
        fe = ferr_cnt[0];
        push_word(tx, 32'h1A5, 9);
        tx = tx[0:4];
        cs_lo(0);
        spi_bits(0, tx, rx);
        cs_hi(0);
        nchk++;
        if (ferr_cnt[0] != fe + 1) $display("FAIL abort_hdr_ferr: got %0d pulses required 1", ferr_cnt[0] - fe);
        else npass++;
        a = $urandom_range(64, 127);
        w = '{$urandom};
        do_write(0, a, w);
        do_read(0, a, 1, r);
        nchk++;
        if (r[0] !== mem_m[0][a] || wc[0] !== 16'd1)
            $display("FAIL after_abort_frame: got %h wc=%h required %h 0001", r[0], wc[0], mem_m[0][a]);
        else npass++;
    endtask

    task automatic test_narrow();
        logic [31:0] w[$];
        logic [31:0] r[$];
        w = '{32'hA5C3};
        do_write(2, 4'hF, w);
        do_read(2, 4'hF, 1, r);
        nchk++;
        if (r[0] !== 32'h0000A5C3) $display("FAIL narrow_rd: got %h required 0000a5c3", r[0]);
        else npass++;
        w = '{$urandom & 32'hFFFF, $urandom & 32'hFFFF};
        do_write(2, 4'hF, w);
        do_read(2, 4'hF, 2, r);
        for (int i = 0; i < 2; i++) begin
            nchk++;
            if (r[i] !== mem_m[2][(15 + i) % 16])
                $display("FAIL narrow_wrap[%0d]: got %h required %h", i, r[i], mem_m[2][(15 + i) % 16]);
            else npass++;
        end
        nchk++;
        if (wc[2] !== 16'd2) $display("FAIL narrow_wc: got %h required 0002", wc[2]);
        else npass++;
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        logic [31:0] r[$];
        int a, len, ra, n, idx, depth;
        for (int d = 0; d < 3; d++) begin
            depth = 1 << AW[d];
            for (int it = 0; it < 4; it++) begin
                a = $urandom_range(0, depth - 1);
                len = $urandom_range(1, 4);
                w = {};
                for (int i = 0; i < len; i++) w.push_back($urandom & dmask(d));
                do_write(d, a, w);
                nchk++;
                if (wc[d] !== 16'(len)) $display("FAIL rnd_wr_wc[%0d]: got %h required %0d", d, wc[d], len);
                else npass++;
                ra = (a + $urandom_range(0, len - 1)) % depth;
                n = $urandom_range(1, 3);
                do_read(d, ra, n, r);
                for (int i = 0; i < n; i++) begin
                    idx = (ra + i) % depth;
                    if (known[d][idx]) begin
                        nchk++;
                        if (r[i] !== mem_m[d][idx])
                            $display("FAIL rnd_rd[%0d] addr %h: got %h required %h", d, idx, r[i], mem_m[d][idx]);
                        else npass++;
                    end
                end
                nchk++;
                if (wc[d] !== 16'(n)) $display("FAIL rnd_rd_wc[%0d]: got %h required %0d", d, wc[d], n);
                else npass++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w[$];
        logic [31:0] r[$];
        bit tx[$];
        logic rx[$];
        logic [31:0] va;
        int fe;
        w = '{$urandom};
        do_write(0, 8'h40, w);
        va = $urandom;
        push_word(tx, 32'h130, 9);
        push_word(tx, va, 32);
        push_word(tx, $urandom, 32);
        tx = tx[0:9+32+10-1];
        cs_lo(0);
        spi_bits(0, tx, rx);
        mem_m[0][8'h30] = va;
        known[0][8'h30] = 1'b1;
        #(2*CLK);
        SRESETn = 1'b0;
        #CLK;
        nchk++;
        if ({so[0], bsy[0], ferr[0]} !== 3'b000 || wc[0] !== 16'd0)
            $display("FAIL midrst_vals: miso/busy/ferr=%b%b%b wc=%h required 000 0000",
                     so[0], bsy[0], ferr[0], wc[0]);
        else npass++;
        #(2*CLK);
        SRESETn = 1'b1;
        fe = ferr_cnt[0];
        tx = {};
        push_word(tx, 32'h140, 9);
        push_word(tx, ~w[0], 32);
        spi_bits(0, tx, rx);
        nchk++;
        if (bsy[0] !== 1'b0 || wc[0] !== 16'd0)
            $display("FAIL midrst_wait_cs: got busy=%b wc=%h required 0 0000", bsy[0], wc[0]);
        else npass++;
        cs_hi(0);
        nchk++;
        if (ferr_cnt[0] != fe) $display("FAIL midrst_ferr: got %0d pulses required 0", ferr_cnt[0] - fe);
        else npass++;
        do_read(0, 8'h40, 1, r);
        nchk++;
        if (r[0] !== mem_m[0][8'h40]) $display("FAIL midrst_ignored: got %h required %h", r[0], mem_m[0][8'h40]);
        else npass++;
        do_read(0, 8'h30, 1, r);
        nchk++;
        if (r[0] !== va) $display("FAIL midrst_kept: got %h required %h", r[0], va);
        else npass++;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            sck[d] = POL[d];
            csn[d] = 1'b1;
            mo[d] = 1'b0;
        end
        #2;
        @(negedge SCLK);
        test_reset();
        test_mode0_basic();
        test_burst_wrap();
        test_abort_word();
        test_abort_header();
        test_narrow();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
